// File: rtl/muldiv_pkg.sv
// Shared definitions for the EX-stage iterative multiply/divide unit:
// opcode encodings, FSM states and datapath sizing.
package muldiv_pkg;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned ITER  = 32;

    typedef enum logic [1:0] {
        MD_MULT  = 2'b00,
        MD_MULTU = 2'b01,
        MD_DIV   = 2'b10,
        MD_DIVU  = 2'b11
    } md_op_e;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIX,
        DONE
    } md_state_e;

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the multiply/divide datapath: a shift-add product step
// (multiplier LSB first) or a restoring-division step (dividend MSB first).
module muldiv_step
    import muldiv_pkg::*;
(
    input  logic                 i_div,
    input  logic [2*WIDTH-1:0]   i_acc,
    input  logic [WIDTH-1:0]     i_opd,
    input  logic                 i_bit,
    output logic [2*WIDTH-1:0]   o_acc,
    output logic                 o_qbit
);

    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_trial;
    logic [WIDTH-1:0] w_diff;

    always_comb begin
        w_sum   = {1'b0, i_acc[2*WIDTH-1:WIDTH]} + (i_bit ? {1'b0, i_opd} : '0);
        // 33-bit partial remainder; on a successful subtract the difference fits in WIDTH bits
        w_trial = {i_acc[2*WIDTH-1:WIDTH], i_bit};
        w_diff  = w_trial[WIDTH-1:0] - i_opd;
        o_qbit  = 1'b0;
        o_acc   = '0;
        if (i_div) begin
            o_qbit = (w_trial >= {1'b0, i_opd});
            o_acc  = {(o_qbit ? w_diff : w_trial[WIDTH-1:0]), i_acc[WIDTH-2:0], 1'b0};
        end else begin
            o_acc  = {w_sum, i_acc[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/ex_muldiv_unit.sv
// Iterative 32-bit MULT/MULTU/DIV/DIVU unit in EX; stalls the front end while
// it iterates and delivers {Hi,Lo} with a one-cycle done pulse.
module ex_muldiv_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic                 Clk,
    input  logic                 Rst,
    input  logic                 StartIn,
    input  logic [1:0]           OpIn,
    input  logic [WIDTH-1:0]     ReadData1In,
    input  logic [WIDTH-1:0]     ReadData2In,
    input  logic                 FlushIn,
    output logic                 BusyOut,
    output logic                 StallOut,
    output logic                 DoneOut,
    output logic [2*WIDTH-1:0]   HiLoOut,
    output logic                 DivZeroOut
);

    import muldiv_pkg::*;

    localparam int unsigned CNTW = $clog2(ITER);
    localparam logic [CNTW-1:0] LAST = '1;

    md_state_e              r_state, w_next;
    md_op_e                 r_op;
    logic [WIDTH-1:0]       r_a, r_b;
    logic                   r_sa, r_sb, r_bz;
    logic [CNTW-1:0]        r_cnt;
    logic [2*WIDTH-1:0]     r_acc, r_hilo;
    logic                   r_dz;

    logic                   w_start, w_div, w_start_signed, w_bit, w_qbit;
    logic [2*WIDTH-1:0]     w_step_acc, w_fix;
    logic [WIDTH-1:0]       w_quo, w_rem, w_a_raw;

    assign w_start        = StartIn & ~FlushIn;
    assign w_start_signed = (OpIn == MD_MULT) | (OpIn == MD_DIV);
    assign w_div          = (r_op == MD_DIV) | (r_op == MD_DIVU);
    assign w_bit          = w_div ? r_a[LAST - r_cnt] : r_b[r_cnt];

    muldiv_step u_step (
        .i_div  (w_div),
        .i_acc  (r_acc),
        .i_opd  (w_div ? r_b : r_a),
        .i_bit  (w_bit),
        .o_acc  (w_step_acc),
        .o_qbit (w_qbit)
    );

    // Sign flags are only ever set for signed ops, so FIX needs no opcode check.
    always_comb begin
        w_a_raw = r_sa ? -r_a : r_a;
        w_quo   = (r_sa ^ r_sb) ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
        w_rem   = r_sa ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];
        w_fix   = (r_sa ^ r_sb) ? -r_acc : r_acc;
        if (w_div) begin
            w_fix = r_bz ? {w_a_raw, {WIDTH{1'b1}}} : {w_rem, w_quo};
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:    if (w_start) w_next = RUN;
            RUN:     if (FlushIn) w_next = IDLE;
                     else if (r_cnt == LAST) w_next = FIX;
            FIX:     w_next = FlushIn ? IDLE : DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_op   <= MD_MULT;
            r_a    <= '0;
            r_b    <= '0;
            r_sa   <= 1'b0;
            r_sb   <= 1'b0;
            r_bz   <= 1'b0;
            r_cnt  <= '0;
            r_acc  <= '0;
            r_hilo <= '0;
            r_dz   <= 1'b0;
        end else begin
            unique case (r_state)
                IDLE: if (w_start) begin
                    r_op  <= md_op_e'(OpIn);
                    r_sa  <= w_start_signed & ReadData1In[WIDTH-1];
                    r_sb  <= w_start_signed & ReadData2In[WIDTH-1];
                    r_a   <= (w_start_signed & ReadData1In[WIDTH-1]) ? -ReadData1In : ReadData1In;
                    r_b   <= (w_start_signed & ReadData2In[WIDTH-1]) ? -ReadData2In : ReadData2In;
                    r_bz  <= (ReadData2In == '0);
                    r_cnt <= '0;
                    r_acc <= '0;
                end
                RUN: begin
                    r_acc <= {w_step_acc[2*WIDTH-1:1], w_div ? w_qbit : w_step_acc[0]};
                    r_cnt <= r_cnt + 1'b1;
                end
                FIX: if (!FlushIn) begin
                    r_hilo <= w_fix;
                    r_dz   <= r_bz;
                end
                default: ;
            endcase
        end
    end

    assign BusyOut    = (r_state == RUN) | (r_state == FIX);
    assign StallOut   = BusyOut | ((r_state == IDLE) & w_start);
    assign DoneOut    = (r_state == DONE);
    assign HiLoOut    = r_hilo;
    assign DivZeroOut = r_dz;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Directed bench for ex_muldiv_unit: expected results are queued at issue
// and compared when DoneOut fires; handshake timing is checked along the way.
module tb_ex_muldiv_unit;

    logic        Clk = 1'b0;
    logic        Rst, StartIn, FlushIn;
    logic [1:0]  OpIn;
    logic [31:0] ReadData1In, ReadData2In;
    logic        BusyOut, StallOut, DoneOut, DivZeroOut;
    logic [63:0] HiLoOut;

    int unsigned tests = 0;
    int unsigned fails = 0;
    logic [64:0] sb_q[$];

    ex_muldiv_unit #(.WIDTH(32)) dut (
        .Clk         (Clk),
        .Rst         (Rst),
        .StartIn     (StartIn),
        .OpIn        (OpIn),
        .ReadData1In (ReadData1In),
        .ReadData2In (ReadData2In),
        .FlushIn     (FlushIn),
        .BusyOut     (BusyOut),
        .StallOut    (StallOut),
        .DoneOut     (DoneOut),
        .HiLoOut     (HiLoOut),
        .DivZeroOut  (DivZeroOut)
    );

    always #5 Clk = ~Clk;

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference arithmetic, independent of the iterative datapath.
    function automatic logic [64:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        logic [63:0] ua, ub, res;
        sa = $signed(a);
        sb = $signed(b);
        ua = {32'd0, a};
        ub = {32'd0, b};
        if (op[1] && b == 32'd0) return {1'b1, a, 32'hFFFF_FFFF};
        case (op)
            2'b00:   res = sa * sb;
            2'b01:   res = ua * ub;
            2'b10:   begin q = sa / sb; r = sa % sb; res = {r[31:0], q[31:0]}; end
            default: res = {ua[31:0] % ub[31:0], ua[31:0] / ub[31:0]};
        endcase
        return {1'b0, res};
    endfunction

    task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [64:0] exp, input bit hold);
        int n;
        bit stall_ok;
        logic [64:0] e;
        sb_q.push_back(exp);
        OpIn = op; ReadData1In = a; ReadData2In = b; StartIn = 1'b1;
        #1;
        check({tag, ".stall_issue"}, {63'd0, StallOut}, 64'd1);
        tick();
        if (!hold) StartIn = 1'b0;
        OpIn = 2'($urandom); ReadData1In = $urandom; ReadData2In = $urandom;
        n = 0;
        stall_ok = 1'b1;
        while (n < 40 && !DoneOut) begin
            if (!(StallOut && BusyOut)) stall_ok = 1'b0;
            tick();
            n++;
        end
        check({tag, ".stall_busy_run"}, {63'd0, stall_ok}, 64'd1);
        check({tag, ".latency"}, 64'(n), 64'd33);
        check({tag, ".stall_done"}, {62'd0, StallOut, BusyOut}, 64'd0);
        tests++;
        assert (sb_q.size() != 0) else begin
            fails++;
            $error("FAIL %s.scoreboard observed=empty expected=entry", tag);
        end
        if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            check({tag, ".hilo"}, HiLoOut, e[63:0]);
            check({tag, ".divzero"}, {63'd0, DivZeroOut}, {63'd0, e[64]});
        end
        tick();
        if (hold) StartIn = 1'b0;
        check({tag, ".done_pulse"}, {62'd0, DoneOut, BusyOut}, 64'd0);
    endtask

    initial begin
        bit done_seen;
        Rst = 1'b1; StartIn = 1'b0; FlushIn = 1'b0; OpIn = 2'b00;
        ReadData1In = '0; ReadData2In = '0;
        tick(); tick();
        check("reset.busy",  {63'd0, BusyOut},    64'd0);
        check("reset.stall", {63'd0, StallOut},   64'd0);
        check("reset.done",  {63'd0, DoneOut},    64'd0);
        check("reset.hilo",  HiLoOut,             64'd0);
        check("reset.dz",    {63'd0, DivZeroOut}, 64'd0);
        Rst = 1'b0;
        tick();

        run_op("mult_7_m3",    2'b00, 32'd7,          32'hFFFF_FFFD, {1'b0, 64'hFFFF_FFFF_FFFF_FFEB}, 1'b0);
        run_op("multu_max",    2'b01, 32'hFFFF_FFFF,  32'hFFFF_FFFF, {1'b0, 64'hFFFF_FFFE_0000_0001}, 1'b0);
        run_op("div_m7_2",     2'b10, 32'hFFFF_FFF9,  32'd2,         {1'b0, 64'hFFFF_FFFF_FFFF_FFFD}, 1'b0);
        run_op("div_ovf",      2'b10, 32'h8000_0000,  32'hFFFF_FFFF, {1'b0, 64'h0000_0000_8000_0000}, 1'b0);
        run_op("divu_by_zero", 2'b11, 32'd100,        32'd0,         {1'b1, 64'h0000_0064_FFFF_FFFF}, 1'b0);

        // Flush at RUN count 10: no result, outputs keep the previous values.
        OpIn = 2'b01; ReadData1In = 32'h1234_5678; ReadData2In = 32'h9ABC; StartIn = 1'b1;
        tick();
        StartIn = 1'b0;
        repeat (10) tick();
        FlushIn = 1'b1;
        tick();
        FlushIn = 1'b0;
        check("flush.busy", {63'd0, BusyOut},    64'd0);
        check("flush.hilo", HiLoOut,             64'h0000_0064_FFFF_FFFF);
        check("flush.dz",   {63'd0, DivZeroOut}, 64'd1);
        done_seen = 1'b0;
        repeat (30) begin
            if (DoneOut) done_seen = 1'b1;
            tick();
        end
        check("flush.no_done", {63'd0, done_seen}, 64'd0);

        run_op("divu_9_4",      2'b11, 32'd9,         32'd4,         {1'b0, 64'h0000_0001_0000_0002}, 1'b0);
        run_op("div_7_m2",      2'b10, 32'd7,         32'hFFFF_FFFE, model(2'b10, 32'd7, 32'hFFFF_FFFE), 1'b0);
        run_op("div_zero_neg",  2'b10, 32'hFFFF_FF00, 32'd0,         model(2'b10, 32'hFFFF_FF00, 32'd0), 1'b0);
        run_op("mult_hold",     2'b00, 32'hFFFF_FFFB, 32'hFFFF_FFFA, model(2'b00, 32'hFFFF_FFFB, 32'hFFFF_FFFA), 1'b1);
        check("hold.idle_after", {63'd0, BusyOut}, 64'd0);

        // Reset at RUN count 20 returns every output to its reset value.
        OpIn = 2'b10; ReadData1In = 32'd1000; ReadData2In = 32'd7; StartIn = 1'b1;
        tick();
        StartIn = 1'b0;
        repeat (20) tick();
        Rst = 1'b1;
        tick();
        check("rst_mid.busy",  {63'd0, BusyOut},    64'd0);
        check("rst_mid.stall", {63'd0, StallOut},   64'd0);
        check("rst_mid.done",  {63'd0, DoneOut},    64'd0);
        check("rst_mid.hilo",  HiLoOut,             64'd0);
        check("rst_mid.dz",    {63'd0, DivZeroOut}, 64'd0);
        Rst = 1'b0;
        tick();

        run_op("multu_after_rst", 2'b01, 32'hDEAD_BEEF, 32'h0000_1234, model(2'b01, 32'hDEAD_BEEF, 32'h0000_1234), 1'b0);
        run_op("divu_big",        2'b11, 32'hF000_0001, 32'h0001_0003, model(2'b11, 32'hF000_0001, 32'h0001_0003), 1'b0);

        tests++;
        assert (sb_q.size() == 0) else begin
            fails++;
            $error("FAIL scoreboard.drain observed=%0d expected=0", sb_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
